// File: rtl/store_buffer_unit_pkg.sv
// Shared constants and entry layout for the RV32I store buffer.
// The optional store-to-load forwarding path is enabled with macro STORE_FWD_EN.
package store_buffer_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    localparam int ENT_ADDR_W = 30;
    localparam int ENT_DATA_W = 32;
    localparam int ENT_BE_W   = 4;

    typedef struct packed {
        logic [ENT_ADDR_W-1:0] addr;
        logic [ENT_DATA_W-1:0] data;
        logic [ENT_BE_W-1:0]   be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_unit_align.sv
// Combinational lane steering and misalignment detection for sb/sh/sw.
// Part of store_buffer_unit (optional feature macro: STORE_FWD_EN, unused here).
module store_align
    import store_buffer_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        err
);

    always_comb begin
        wdata = '0;
        be    = '0;
        err   = 1'b0;
        case (funct3)
            FUNCT3_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            FUNCT3_SH: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
                err   = addr_lo[0];
            end
            FUNCT3_SW: begin
                be    = 4'b1111;
                wdata = data;
                err   = (addr_lo != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer_unit.sv
// In-order store buffer: steers RV32I stores onto word lanes and drains them over req/gnt.
// Define STORE_FWD_EN to add the combinational store-to-load forwarding port set.
module store_buffer_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_data,
    input  logic [2:0]      funct3,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    output logic            misalign_err,
`ifdef STORE_FWD_EN
    input  logic [XLEN-1:0] ld_addr,
    output logic [XLEN-1:0] fwd_data,
    output logic [3:0]      fwd_be,
`endif
    output logic            sb_empty
);
    import store_buffer_unit_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t          entries_q [DEPTH];
    sb_entry_t          entries_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               misalign_err_q, misalign_err_d;

    logic [31:0]        align_wdata;
    logic [3:0]         align_be;
    logic               align_err;
    logic               accept;
    logic               push;
    logic               pop;
    sb_entry_t          head_entry;

    store_align u_align (
        .addr_lo (st_addr[1:0]),
        .data    (st_data),
        .funct3  (funct3),
        .wdata   (align_wdata),
        .be      (align_be),
        .err     (align_err)
    );

    assign st_ready = (count_q != CNT_W'(DEPTH));
    assign sb_empty = (count_q == '0);
    assign mem_req  = !sb_empty;

    // Illegal requests complete the handshake but never reach the queue.
    assign accept = st_valid && st_ready;
    assign push   = accept && !align_err;
    assign pop    = mem_req && mem_gnt;

    assign head_entry   = entries_q[head_q];
    assign mem_addr     = mem_req ? {head_entry.addr, 2'b00} : '0;
    assign mem_wdata    = mem_req ? head_entry.data : '0;
    assign mem_be       = mem_req ? head_entry.be : '0;
    assign misalign_err = misalign_err_q;

    always_comb begin
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        misalign_err_d = accept && align_err;
        if (push) begin
            entries_d[tail_q] = '{addr: st_addr[XLEN-1:2], data: align_wdata, be: align_be};
            tail_d            = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            entries_q      <= entries_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            misalign_err_q <= misalign_err_d;
        end
    end

`ifdef STORE_FWD_EN
    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    // Walk oldest to youngest so younger matching bytes overwrite older ones.
    always_comb begin
        logic [PTR_W-1:0] fwd_idx;
        fwd_data = '0;
        fwd_be   = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (entries_q[fwd_idx].addr == ld_addr[XLEN-1:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries_q[fwd_idx].be[b]) begin
                        fwd_data[8*b +: 8] = entries_q[fwd_idx].data[8*b +: 8];
                        fwd_be[b]          = 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer_unit.sv
// Self-checking bench for store_buffer_unit: vector table, corner sequences, random vs queue model.
module tb_store_buffer_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  funct3;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign_err;
    logic        sb_empty;
`ifdef STORE_FWD_EN
    logic [31:0] ld_addr;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_be;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        err;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    vec_t vecs[11];
    exp_t model_q[$];

    store_buffer_unit #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .funct3       (funct3),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .misalign_err (misalign_err),
`ifdef STORE_FWD_EN
        .ld_addr      (ld_addr),
        .fwd_data     (fwd_data),
        .fwd_be       (fwd_be),
`endif
        .sb_empty     (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] f, input logic g);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        funct3   = f;
        mem_gnt  = g;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference steering computed straight from the store-width rules.
    function automatic exp_t steer(input logic [31:0] a, input logic [31:0] d,
                                   input logic [2:0] f, output bit legal);
        exp_t e;
        int   lane;
        lane    = int'(a % 4);
        e.addr  = a & ~32'd3;
        e.wdata = '0;
        e.be    = '0;
        legal   = 1'b0;
        case (f)
            3'd0: begin
                legal   = 1'b1;
                e.be    = 4'(1 << lane);
                e.wdata = (d & 32'hFF) * 32'h0101_0101;
            end
            3'd1: begin
                legal   = (lane % 2 == 0);
                e.be    = 4'(3 << lane);
                e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
            end
            3'd2: begin
                legal   = (lane == 0);
                e.be    = 4'hF;
                e.wdata = d;
            end
            default: legal = 1'b0;
        endcase
        return e;
    endfunction

    initial begin
        vecs[0]  = '{32'h1003, 32'hAABBCCDD, 3'd0, 1'b0, 32'h1000, 32'hDDDDDDDD, 4'b1000};
        vecs[1]  = '{32'h1002, 32'h12345678, 3'd1, 1'b0, 32'h1000, 32'h56785678, 4'b1100};
        vecs[2]  = '{32'h2000, 32'hDEADBEEF, 3'd2, 1'b0, 32'h2000, 32'hDEADBEEF, 4'b1111};
        vecs[3]  = '{32'h1000, 32'h11223344, 3'd0, 1'b0, 32'h1000, 32'h44444444, 4'b0001};
        vecs[4]  = '{32'h3001, 32'h11223344, 3'd0, 1'b0, 32'h3000, 32'h44444444, 4'b0010};
        vecs[5]  = '{32'h4000, 32'hCAFEF00D, 3'd1, 1'b0, 32'h4000, 32'hF00DF00D, 4'b0011};
        vecs[6]  = '{32'h1001, 32'h01020304, 3'd2, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[7]  = '{32'h2003, 32'h01020304, 3'd1, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[8]  = '{32'h3000, 32'h01020304, 3'd3, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[9]  = '{32'h1002, 32'h01020304, 3'd2, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[10] = '{32'h5000, 32'h01020304, 3'd7, 1'b1, 32'h0, 32'h0, 4'b0000};

        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
`ifdef STORE_FWD_EN
        ld_addr = 32'h0;
`endif
        #12;
        checkOutput("reset_mem_req", mem_req, 0);
        checkOutput("reset_sb_empty", sb_empty, 1);
        checkOutput("reset_st_ready", st_ready, 1);
        checkOutput("reset_misalign", misalign_err, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_mem_wdata", mem_wdata, 0);
        checkOutput("reset_mem_be", mem_be, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single-store vectors: legal ones appear at the head, illegal ones only pulse the error.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].addr, vecs[i].data, vecs[i].f3, 1'b0);
            tick();
            applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
            checkOutput("vec_misalign", misalign_err, vecs[i].err);
            checkOutput("vec_mem_req", mem_req, !vecs[i].err);
            checkOutput("vec_mem_addr", mem_addr, vecs[i].e_addr);
            checkOutput("vec_mem_wdata", mem_wdata, vecs[i].e_wdata);
            checkOutput("vec_mem_be", mem_be, vecs[i].e_be);
            tick();
            checkOutput("vec_misalign_clear", misalign_err, 0);
            checkOutput("vec_mem_req_hold", mem_req, !vecs[i].err);
            if (!vecs[i].err) begin
                mem_gnt = 1'b1;
                tick();
                mem_gnt = 1'b0;
            end
            checkOutput("vec_drained", sb_empty, 1);
        end

        // Backpressure with three back-to-back word stores.
        applyStimulus(1'b1, 32'h100, 32'hA1, 3'd2, 1'b0);
        checkOutput("bp_ready0", st_ready, 1);
        tick();
        checkOutput("bp_ready1", st_ready, 1);
        checkOutput("bp_addr1", mem_addr, 32'h100);
        applyStimulus(1'b1, 32'h104, 32'hA2, 3'd2, 1'b0);
        tick();
        checkOutput("bp_ready_full", st_ready, 0);
        checkOutput("bp_addr_hold", mem_addr, 32'h100);
        applyStimulus(1'b1, 32'h108, 32'hA3, 3'd2, 1'b0);
        tick();
        checkOutput("bp_ready_full2", st_ready, 0);
        checkOutput("bp_addr_hold2", mem_addr, 32'h100);
        checkOutput("bp_wdata_hold", mem_wdata, 32'hA1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checkOutput("bp_ready_after_pop", st_ready, 1);
        checkOutput("bp_head2", mem_addr, 32'h104);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        checkOutput("bp_drain2", mem_addr, 32'h104);
        checkOutput("bp_full_again", st_ready, 0);
        tick();
        checkOutput("bp_drain3", mem_addr, 32'h108);
        checkOutput("bp_drain3_data", mem_wdata, 32'hA3);
        tick();
        mem_gnt = 1'b0;
        checkOutput("bp_empty", sb_empty, 1);

        // Push and pop every cycle at count 1 so the pointers wrap repeatedly.
        applyStimulus(1'b1, 32'h0, 32'hC0DE0000, 3'd2, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k < 7) begin
                applyStimulus(1'b1, 32'(4 * (k + 1)), 32'hC0DE0000 + 32'(k + 1), 3'd2, 1'b1);
            end else begin
                applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
            end
            checkOutput("pp_addr", mem_addr, 32'(4 * k));
            checkOutput("pp_wdata", mem_wdata, 32'hC0DE0000 + 32'(k));
            checkOutput("pp_ready", st_ready, 1);
            checkOutput("pp_not_empty", sb_empty, 0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        checkOutput("pp_empty", sb_empty, 1);

`ifdef STORE_FWD_EN
        applyStimulus(1'b1, 32'h40, 32'h11, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h40, 32'h22, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        ld_addr = 32'h40;
        #1;
        checkOutput("fwd_be_hit", fwd_be, 4'b0001);
        checkOutput("fwd_data_hit", fwd_data, 32'h22);
        ld_addr = 32'h44;
        #1;
        checkOutput("fwd_be_miss", fwd_be, 0);
        checkOutput("fwd_data_miss", fwd_data, 0);
        mem_gnt = 1'b1;
        tick();
        tick();
        mem_gnt = 1'b0;
        checkOutput("fwd_empty", sb_empty, 1);
`endif

        // Reset in the middle of a drain with two entries queued.
        applyStimulus(1'b1, 32'h200, 32'hB1, 3'd2, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h204, 32'hB2, 3'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        checkOutput("rst_pre_req", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_req", mem_req, 0);
        checkOutput("rst_async_empty", sb_empty, 1);
        checkOutput("rst_async_ready", st_ready, 1);
        checkOutput("rst_async_be", mem_be, 0);
        mem_gnt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        checkOutput("rst_no_stale_req", mem_req, 0);
        checkOutput("rst_no_stale_empty", sb_empty, 1);

        // Random traffic against the queue model.
        begin
            bit   err_pending;
            bit   legal;
            exp_t e;
            logic v;
            logic g;
            logic [31:0] a;
            logic [31:0] d;
            logic [2:0]  f;
            int   r;
            err_pending = 1'b0;
            model_q.delete();
            for (int c = 0; c < 400; c++) begin
                v = ($urandom % 4) != 0;
                g = ($urandom % 2) != 0;
                a = $urandom;
                d = $urandom;
                r = int'($urandom % 10);
                f = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'(3 + ($urandom % 5));
                applyStimulus(v, a, d, f, g);
                checkOutput("rnd_mem_req", mem_req, model_q.size() != 0);
                checkOutput("rnd_sb_empty", sb_empty, model_q.size() == 0);
                checkOutput("rnd_st_ready", st_ready, model_q.size() < DEPTH);
                checkOutput("rnd_misalign", misalign_err, err_pending);
                if (model_q.size() != 0) begin
                    checkOutput("rnd_mem_addr", mem_addr, model_q[0].addr);
                    checkOutput("rnd_mem_wdata", mem_wdata, model_q[0].wdata);
                    checkOutput("rnd_mem_be", mem_be, model_q[0].be);
                end else begin
                    checkOutput("rnd_idle_addr", mem_addr, 0);
                    checkOutput("rnd_idle_be", mem_be, 0);
                end
                e = steer(a, d, f, legal);
                err_pending = 1'b0;
                if (v && model_q.size() < DEPTH) begin
                    err_pending = !legal;
                    if (g && model_q.size() != 0) begin
                        void'(model_q.pop_front());
                    end
                    if (legal) begin
                        model_q.push_back(e);
                    end
                end else if (g && model_q.size() != 0) begin
                    void'(model_q.pop_front());
                end
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
- Store-side counterpart of the load extraction path in the memory stage.
- Takes RV32I store requests (sb/sh/sw) from the pipeline and steers byte/halfword data onto the correct word lanes with byte enables.
- Queues aligned stores in a small in-order FIFO and drains them to the data memory over a req/gnt handshake.
- Flags misaligned or illegal stores.

Parameters:
- XLEN, 32, data/address width (matches `XLEN; only 32 supported)
- DEPTH, 2, store buffer entries (power of two, 2..8)

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- st_valid  input  1  store request valid from memory stage
- st_ready  output  1  buffer can accept; a transfer occurs when st_valid && st_ready
- st_addr  input  XLEN  byte address
- st_data  input  XLEN  rs2 value, unaligned; low bits used for sb/sh
- funct3  input  3  store width: 000 sb, 001 sh, 010 sw
- mem_req  output  1  head entry valid toward data memory
- mem_gnt  input  1  memory accepts head this cycle
- mem_addr  output  XLEN  word-aligned address {addr[31:2],2'b00}
- mem_wdata  output  XLEN  lane-steered write data
- mem_be  output  4  byte enables, bit i = byte lane i
- misalign_err  output  1  one-cycle pulse, request dropped
- sb_empty  output  1  buffer empty; used by fence/load ordering

Behaviour:
- Reset (async, active-high) values:
  - pointers and count are 0.
  - mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - misalign_err=0, sb_empty=1, st_ready=1.
  - Reset mid-operation discards all queued stores; nothing is replayed.
- Lane steering, applied on acceptance and stored in the entry:
  - sb: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - sh: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - sw: be = 4'b1111; wdata = data.
- Errors:
  - The request is an error if any of: sh with addr[0]=1; sw with addr[1:0]!=0; funct3 not in {000,001,010}.
  - An error request is consumed (the handshake completes) but not enqueued.
  - misalign_err is registered: it is 1 in the cycle after acceptance, then returns to 0.
- FIFO occupancy:
  - Count ranges 0..DEPTH.
  - st_ready = (count != DEPTH).
  - sb_empty = (count == 0).
- Drain side:
  - mem_req = !sb_empty.
  - mem_addr, mem_wdata and mem_be present the head entry; they are 0 when empty.
  - The head must stay stable while mem_req=1 && mem_gnt=0.
  - The head pops on mem_req && mem_gnt.
- Latency: a store accepted in cycle N raises mem_req no earlier than N+1. There is no combinational bypass from st_* to mem_*.
- Simultaneous push and pop:
  - Count is unchanged; the head advances and the tail writes.
  - This is legal at any count < DEPTH.
  - At count == DEPTH push is blocked by st_ready even if a pop occurs that cycle; st_ready does not depend on mem_gnt.
- Pointers wrap modulo DEPTH.
- mem_gnt while empty is ignored.
- Ordering is strictly FIFO; no store merging.

Optional Feature:
- Macro STORE_FWD_EN.
- When defined, these ports are added:
  - ld_addr (input, XLEN)
  - fwd_data (output, XLEN)
  - fwd_be (output, 4)
- Forwarding behaviour (combinational):
  - Every valid entry whose word address matches ld_addr[31:2] is compared.
  - Overlapping bytes are merged with the youngest entry winning.
  - fwd_be is the OR of the matching byte enables; fwd_data carries the merged bytes, with 0 in uncovered lanes.
- When not defined, the ports are absent and there is no comparator logic.
- The load path treats fwd_be==0 as a miss.

Decomposition:
- The shared defines file RV32I_defines.v holds:
  - FUNCT3_SB, FUNCT3_SH, FUNCT3_SW constants
  - `XLEN
  - the entry field widths: addr 30 bits, data 32, be 4
- One combinational sub-module, store_align, does the lane steering and error detection:
  - inputs: addr[1:0], data, funct3
  - outputs: wdata, be, err
- The FIFO, handshake and optional forwarding stay in store_buffer_unit.

Test Plan:
- Reset:
  - Stimulus: assert reset mid-drain with 2 entries queued.
  - Required response: mem_req=0, sb_empty=1, st_ready=1 asynchronously; no stale entry after release.
- Lane steering:
  - Stimulus: sb to 0x1003 with data 0xAABBCCDD.
  - Required response: mem_addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD.
  - Stimulus: sh to 0x1002 with data 0x12345678.
  - Required response: be=4'b1100, wdata=0x56785678.
- Misaligned and illegal:
  - Stimulus: sw to 0x1001; sh to 0x2003; funct3=011.
  - Required response: misalign_err pulses one cycle each; mem_req is never raised.
- Backpressure:
  - Stimulus: DEPTH=2, mem_gnt=0, three back-to-back sw.
  - Required response: st_ready drops after the 2nd store; mem_addr is held stable.
  - Stimulus: then gnt for 1 cycle.
  - Required response: the 3rd store is accepted in the next cycle; the drain order is 1, 2, 3.
- Simultaneous push and pop:
  - Stimulus: count=1 with mem_gnt=1 and st_valid=1 every cycle for 8 cycles, addresses 0x0..0x1C.
  - Required response: count stays 1; the memory sees all 8 stores in order; pointers wrap.
- STORE_FWD_EN:
  - Stimulus: queue sb 0x11 to 0x40, then sb 0x22 to 0x40; ld_addr=0x40.
  - Required response: fwd_be=4'b0001, fwd_data[7:0]=0x22.
  - Stimulus: ld_addr=0x44.
  - Required response: fwd_be=0.
